// File: rtl/ascon_ti_ctrl_pkg.sv
// ascon_ti_ctrl_pkg
// Shared definitions for the ASCON threshold-implementation sequencer:
// FSM state encoding, default operation geometry and the address width
// of the bit-serial load/unload word mux.
package ascon_ti_ctrl_pkg;

    localparam int ADDR_W        = 12;
    localparam int DATA_BITS_DEF = 128;
    localparam int LOAD_LAT_DEF  = 2;
    localparam int TIMEOUT_DEF   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_FIN    = 3'd5
    } ctrl_state_t;

    // One bit wider than needed to hold TIMEOUT-1, so the counter can
    // saturate without ever aliasing back onto the abort threshold.
    function automatic int run_cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/ascon_ti_seq_ctrl_if.sv
// ascon_ti_seq_ctrl_if
// Handshake/status bundle between the sequencer and its surroundings.
//   start_i, core_done_i         : requests into the sequencer
//   w_addr_o, w_en_o             : bit index and capture enable for the word mux
//   load_valid_o, core_start_o   : core-side strobes
//   busy_o, done_o, err_o, trig_o: status and scope trigger
// Modport master = host/environment side, slave = sequencer side.
interface ascon_ti_seq_ctrl_if;
    import ascon_ti_ctrl_pkg::*;

    logic              start_i;
    logic              core_done_i;
    logic [ADDR_W-1:0] w_addr_o;
    logic              w_en_o;
    logic              load_valid_o;
    logic              core_start_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              trig_o;

    modport master (
        output start_i, core_done_i,
        input  w_addr_o, w_en_o, load_valid_o, core_start_o,
        input  busy_o, done_o, err_o, trig_o
    );

    modport slave (
        input  start_i, core_done_i,
        output w_addr_o, w_en_o, load_valid_o, core_start_o,
        output busy_o, done_o, err_o, trig_o
    );
endinterface

// File: rtl/ascon_ti_vdelay.sv
// ascon_ti_vdelay
// Single-bit delay line of DEPTH flops (DEPTH >= 1); dout is the last
// flop, so the delayed signal is registered.
//   crypto_clk : clock
//   rst_ni     : asynchronous active-low reset, clears every tap
//   din        : bit to delay
//   dout       : din delayed by DEPTH cycles
module ascon_ti_vdelay #(
    parameter int DEPTH = 2
) (
    input  logic crypto_clk,
    input  logic rst_ni,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] tap_reg;
    logic [DEPTH-1:0] tap_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign tap_next[gi] = din;
            end else begin : g_body
                assign tap_next[gi] = tap_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge crypto_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tap_reg <= '0;
        end else begin
            tap_reg <= tap_next;
        end
    end

    assign dout = tap_reg[DEPTH-1];

endmodule

// File: rtl/ascon_ti_seq_ctrl.sv
// ascon_ti_seq_ctrl
// Sequencer for a masked ASCON core: bit-serially loads the share word
// (LOAD), waits for the load pipeline to drain (FLUSH), starts the core
// and waits for its done edge or a timeout (RUN), bit-serially unloads
// the result (UNLOAD) and reports completion (FIN).
//   crypto_clk : sole clock
//   rst_ni     : asynchronous active-low reset
//   bus        : ascon_ti_seq_ctrl_if.slave (start/done in, strobes/status out)
// Every output is a flop; outputs are decoded from the next state so they
// line up with the state they describe. LOAD_LAT must be at least 1.
module ascon_ti_seq_ctrl
    import ascon_ti_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LOAD_LAT  = LOAD_LAT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input logic               crypto_clk,
    input logic               rst_ni,
    ascon_ti_seq_ctrl_if.slave bus
);

    localparam int RUN_W   = run_cnt_width(TIMEOUT);
    localparam int FLUSH_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DATA_BITS - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(TIMEOUT - 1);
    localparam logic [RUN_W-1:0]   RUN_SAT    = '1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(LOAD_LAT - 1);

    ctrl_state_t        state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [RUN_W-1:0]   run_cnt_reg, run_cnt_next;
    logic [FLUSH_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic               err_reg, err_next;
    logic               busy_reg, done_reg, trig_reg, core_start_reg, w_en_reg;
    logic               done_q_reg;
    logic               done_rise;
    logic               in_load;
    logic               load_valid;

    // done_q follows core_done_i in every state, so a level that is already
    // high when RUN is entered never produces a rise.
    assign done_rise = bus.core_done_i & ~done_q_reg;
    assign in_load   = (state_reg == ST_LOAD);

    always_comb begin
        state_next     = state_reg;
        addr_next      = '0;
        run_cnt_next   = '0;
        flush_cnt_next = '0;
        err_next       = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_next = ST_LOAD;
                    err_next   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (addr_reg == ADDR_LAST) begin
                    state_next = ST_FLUSH;
                end else begin
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_reg == FLUSH_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt_reg + FLUSH_W'(1);
                end
            end
            ST_RUN: begin
                // A done edge in the last allowed cycle still wins over abort.
                if (done_rise) begin
                    state_next = ST_UNLOAD;
                end else if (run_cnt_reg == RUN_LAST) begin
                    state_next = ST_FIN;
                    err_next   = 1'b1;
                end else if (run_cnt_reg == RUN_SAT) begin
                    run_cnt_next = run_cnt_reg;
                end else begin
                    run_cnt_next = run_cnt_reg + RUN_W'(1);
                end
            end
            ST_UNLOAD: begin
                if (addr_reg == ADDR_LAST) begin
                    state_next = ST_FIN;
                end else begin
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge crypto_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            run_cnt_reg    <= '0;
            flush_cnt_reg  <= '0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            trig_reg       <= 1'b0;
            core_start_reg <= 1'b0;
            w_en_reg       <= 1'b0;
            done_q_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            run_cnt_reg    <= run_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
            err_reg        <= err_next;
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_FIN);
            trig_reg       <= (state_next == ST_RUN);
            core_start_reg <= (state_next == ST_RUN) && (state_reg != ST_RUN);
            w_en_reg       <= (state_next == ST_UNLOAD);
            done_q_reg     <= bus.core_done_i;
        end
    end

    // "in LOAD" delayed by LOAD_LAT flops marks the share word at the core input.
    ascon_ti_vdelay #(
        .DEPTH (LOAD_LAT)
    ) u_vdelay (
        .crypto_clk (crypto_clk),
        .rst_ni     (rst_ni),
        .din        (in_load),
        .dout       (load_valid)
    );

    assign bus.w_addr_o     = addr_reg;
    assign bus.w_en_o       = w_en_reg;
    assign bus.load_valid_o = load_valid;
    assign bus.core_start_o = core_start_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.done_o       = done_reg;
    assign bus.err_o        = err_reg;
    assign bus.trig_o       = trig_reg;

endmodule

// File: tb/tb_ascon_ti_seq_ctrl.sv
// tb_ascon_ti_seq_ctrl
// Two sequencer instances: A (128/2/4096) for nominal, busy-start, stale
// done and mid-operation reset; B (8/3/16) for timeout and RUN window edges.
// Each operation is described by start/done waveforms; the expected outputs
// for every cycle come from a timeline computed with plain arithmetic.
module tb_ascon_ti_seq_ctrl;
    import ascon_ti_ctrl_pkg::*;

    localparam int A_DB = 128, A_LAT = 2, A_TO = 4096;
    localparam int B_DB = 8,   B_LAT = 3, B_TO = 16;
    localparam int WMAX = 1024;

    logic crypto_clk = 1'b0;
    logic rst_ni     = 1'b1;

    int checks   = 0;
    int failures = 0;
    int op_id    = 0;
    bit err_mem [2];
    bit start_w [WMAX];
    bit done_w  [WMAX];

    ascon_ti_seq_ctrl_if ifa ();
    ascon_ti_seq_ctrl_if ifb ();

    ascon_ti_seq_ctrl #(.DATA_BITS(A_DB), .LOAD_LAT(A_LAT), .TIMEOUT(A_TO)) dut_a (
        .crypto_clk (crypto_clk),
        .rst_ni     (rst_ni),
        .bus        (ifa)
    );

    ascon_ti_seq_ctrl #(.DATA_BITS(B_DB), .LOAD_LAT(B_LAT), .TIMEOUT(B_TO)) dut_b (
        .crypto_clk (crypto_clk),
        .rst_ni     (rst_ni),
        .bus        (ifb)
    );

    always #5 crypto_clk = ~crypto_clk;

    // Packed view: {busy, done, err, trig, core_start, load_valid, w_en, addr[11:0]}
    function automatic logic [18:0] model_out(input int t, input int db, input int lat,
                                              input int to, input int e, input bit perr);
        int r0, fin, run_end;
        bit tmo, ld, ul;
        logic [11:0] addr;
        r0      = db + lat + 1;
        tmo     = (e < 0);
        fin     = tmo ? r0 + to : e + db + 1;
        run_end = tmo ? fin - 1 : e;
        ld      = (t >= 1) && (t <= db);
        ul      = !tmo && (t >= e + 1) && (t <= e + db);
        addr    = ld ? 12'(t - 1) : (ul ? 12'(t - e - 1) : 12'd0);
        return {(t >= 1) && (t <= fin), t == fin, (t == 0) ? perr : (tmo && t >= fin),
                (t >= r0) && (t <= run_end), t == r0,
                (t >= lat + 1) && (t <= db + lat), ul, addr};
    endfunction

    function automatic logic [18:0] sample(input int which);
        if (which == 0)
            return {ifa.busy_o, ifa.done_o, ifa.err_o, ifa.trig_o, ifa.core_start_o,
                    ifa.load_valid_o, ifa.w_en_o, ifa.w_addr_o};
        return {ifb.busy_o, ifb.done_o, ifb.err_o, ifb.trig_o, ifb.core_start_o,
                ifb.load_valid_o, ifb.w_en_o, ifb.w_addr_o};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int which, input bit s, input bit dn);
        if (which == 0) begin
            ifa.start_i     = s;
            ifa.core_done_i = dn;
        end else begin
            ifb.start_i     = s;
            ifb.core_done_i = dn;
        end
    endtask

    // mode 0: done pulse of width w at RUN entry + d
    // mode 1: done high from before RUN entry until RUN entry + d, low w cycles, then high
    // mode 2: done never asserted
    // mode 3: done pulse coinciding with the start cycle, plus a mode 0 pulse
    task automatic run_op(input int which, input int mode, input int d, input int w,
                          input int n_extra, input int fixed_extra, input int rst_at);
        int db, lat, to, r0, e, fin;
        bit perr;
        db  = (which == 0) ? A_DB  : B_DB;
        lat = (which == 0) ? A_LAT : B_LAT;
        to  = (which == 0) ? A_TO  : B_TO;
        r0  = db + lat + 1;
        for (int i = 0; i < WMAX; i++) begin
            start_w[i] = 1'b0;
            done_w[i]  = 1'b0;
        end
        start_w[0] = 1'b1;
        if (mode == 3) done_w[0] = 1'b1;
        if (mode == 0 || mode == 3) begin
            for (int k = 0; k < w; k++) done_w[r0 + d + k] = 1'b1;
        end else if (mode == 1) begin
            for (int k = r0 - 3; k <= r0 + d; k++) done_w[k] = 1'b1;
            for (int k = r0 + d + 1 + w; k < WMAX; k++) done_w[k] = 1'b1;
        end
        // First rising edge of core_done_i inside the RUN window.
        e = -1;
        for (int t = r0; t < r0 + to; t++) begin
            if (done_w[t] && !done_w[t-1]) begin
                e = t;
                break;
            end
        end
        fin = (e < 0) ? r0 + to : e + db + 1;
        for (int k = 0; k < n_extra; k++) start_w[$urandom_range(1, fin)] = 1'b1;
        if (fixed_extra > 0) start_w[fixed_extra] = 1'b1;
        perr = err_mem[which];
        op_id++;
        for (int t = 0; t <= fin + 1; t++) begin
            @(posedge crypto_clk);
            #1;
            drive(which, start_w[t], done_w[t]);
            @(negedge crypto_clk);
            check($sformatf("op%0d_inst%0d_t%0d", op_id, which, t), sample(which),
                  model_out(t, db, lat, to, e, perr));
            if (t == rst_at) begin
                rst_ni = 1'b0;
                #1;
                check($sformatf("op%0d_rst_async", op_id), sample(which), 19'd0);
                @(posedge crypto_clk);
                #1;
                check($sformatf("op%0d_rst_edge", op_id), sample(which), 19'd0);
                drive(which, 1'b0, 1'b0);
                @(negedge crypto_clk);
                rst_ni     = 1'b1;
                err_mem[0] = 1'b0;
                err_mem[1] = 1'b0;
                $display("op %0d inst=%0d reset at t=%0d", op_id, which, t);
                return;
            end
        end
        drive(which, 1'b0, 1'b0);
        err_mem[which] = (e < 0);
        $display("op %0d inst=%0d mode=%0d edge_t=%0d fin_t=%0d err=%0d",
                 op_id, which, mode, e, fin, (e < 0));
    endtask

    initial begin
        int m;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        err_mem[0] = 1'b0;
        err_mem[1] = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("reset_a", sample(0), 19'd0);
        check("reset_b", sample(1), 19'd0);
        repeat (3) @(posedge crypto_clk);
        @(negedge crypto_clk);
        check("reset_hold_a", sample(0), 19'd0);
        rst_ni = 1'b1;

        // Instance A directed steps
        run_op(0, 0, 40, 1, 0, -1, -1);   // nominal, done pulse 40 cycles after core start
        run_op(0, 0, 40, 1, 0, 50, -1);   // second start at cycle 50 is ignored
        run_op(0, 1, 10, 5, 0, -1, -1);   // stale done level, only the later rise counts
        run_op(0, 3, 5, 2, 2, -1, -1);    // start and done edge together in IDLE
        run_op(0, 0, 40, 1, 0, -1, 60);   // reset in the 60th LOAD cycle
        run_op(0, 0, 40, 1, 0, -1, -1);   // fresh start after reset

        // Instance B directed steps
        run_op(1, 2, 0, 0, 0, -1, -1);    // timeout, err set
        run_op(1, 0, 0, 1, 0, -1, -1);    // edge in first RUN cycle, err cleared by start
        run_op(1, 0, 15, 1, 0, -1, -1);   // edge in last RUN cycle
        run_op(1, 0, 16, 1, 1, -1, -1);   // edge one cycle too late -> timeout
        run_op(1, 1, 2, 1, 0, -1, -1);    // stale done on small instance

        // Randomized operations
        for (int i = 0; i < 6; i++) begin
            m = $urandom_range(0, 2);
            if (m == 2) m = 3;
            run_op(0, m, $urandom_range(0, 60), $urandom_range(1, 3), $urandom_range(0, 3), -1, -1);
        end
        for (int i = 0; i < 12; i++) begin
            run_op(1, $urandom_range(0, 3), $urandom_range(0, 20), $urandom_range(1, 3),
                   $urandom_range(0, 3), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_ti_seq_ctrl.md
ASCON_TI_SEQ_CTRL -- requirements
Module: ascon_ti_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 128: number of bit-serial load/unload beats per operation.
REQ-002 SHALL have parameter LOAD_LAT, default 2: cycles from w_addr_o to the share word valid at the core input.
REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum RUN cycles before abort.
REQ-004 SHALL have port crypto_clk, input, 1: sole clock.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1: one-cycle go pulse, already in the crypto_clk domain.
REQ-007 SHALL have port core_done_i, input, 1: core done, level or pulse.
REQ-008 SHALL have port w_addr_o, output, 12: bit index for the load/unload word mux.
REQ-009 SHALL have port w_en_o, output, 1: capture enable for core output/tag bits.
REQ-010 SHALL have port load_valid_o, output, 1: share word at the core input is valid this cycle.
REQ-011 SHALL have port core_start_o, output, 1: one-cycle core start.
REQ-012 SHALL have ports busy_o, done_o and err_o, output, 1 each: status signals.
REQ-013 SHALL have port trig_o, output, 1: scope trigger.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, FLUSH, RUN, UNLOAD and FIN.
REQ-015 IDLE: start_i=1 -> LOAD next cycle; clears err_o; any other input -> stay.
REQ-016 LOAD: w_addr_o = 0..DATA_BITS-1, one step per cycle; after index DATA_BITS-1 -> FLUSH.
REQ-017 load_valid_o SHALL equal "state==LOAD" delayed by LOAD_LAT cycles through a shift register.
REQ-018 FLUSH: lasts exactly LOAD_LAT cycles, so the last load_valid_o beat occurs in the final FLUSH cycle, then -> RUN.
REQ-019 RUN: core_start_o=1 in the first RUN cycle only; trig_o=1 throughout RUN.
REQ-020 RUN: a rising edge of core_done_i (done_i & ~done_q) -> UNLOAD; a level that is already high on RUN entry SHALL NOT count.
REQ-021 RUN: the cycle counter reaching TIMEOUT-1 without a done edge -> FIN with err_o=1.
REQ-022 UNLOAD: w_en_o=1 with w_addr_o = 0..DATA_BITS-1 for DATA_BITS cycles, then -> FIN.
REQ-023 FIN: done_o=1 for exactly one cycle, then -> IDLE.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 start_i while busy_o=1 SHALL be ignored, with no queueing.
REQ-026 w_addr_o SHALL be 0 and w_en_o SHALL be 0 outside LOAD and UNLOAD.
REQ-027 The address counter SHALL be 12 bits and reset to 0 on every LOAD/UNLOAD entry, with no wrap inside a phase.
REQ-028 err_o SHALL be sticky until the next accepted start_i.
REQ-029 A start_i and a done edge in the same cycle in IDLE: start wins, and the done edge is ignored.
REQ-030 The RUN counter SHALL be $clog2(TIMEOUT)+1 bits and saturate.

Reset
REQ-031 rst_ni=0 SHALL asynchronously force IDLE, with all outputs 0, counters 0 and the delay line cleared, including mid-LOAD/RUN/UNLOAD.
REQ-032 After reset release, the first accepted start_i SHALL behave identically to a start from power-up.

Structure
REQ-033 The FSM state enum, the DATA_BITS/LOAD_LAT/TIMEOUT defaults and the 12-bit address width SHALL live in shared package ascon_ti_ctrl_pkg.
REQ-034 The LOAD_LAT delay line SHALL be sub-module ascon_ti_vdelay (parameterised depth, async active-low reset).
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Nominal: DATA_BITS=128, LOAD_LAT=2, start_i at cycle 0, core_done_i pulse 40 cycles after core_start_o. Required response:
- w_addr_o = 0..127 in cycles 1..128.
- load_valid_o in cycles 3..130.
- core_start_o at cycle 131.
- w_en_o for 128 cycles from 1 cycle after the done edge.
- done_o 1 cycle after the last w_en_o.
REQ-037 Timeout: TIMEOUT=16 with core_done_i held 0. Required response: FIN after 16 RUN cycles, err_o=1, done_o pulse, no w_en_o; the next start_i clears err_o.
REQ-038 Busy start: start_i at cycles 0 and 50. Required response: exactly one LOAD sequence and one core_start_o.
REQ-039 Reset mid-op: rst_ni=0 at the 60th LOAD cycle. Required response: next edge shows all outputs 0 and state IDLE; a fresh start_i reproduces the nominal timing.
REQ-040 Stale done: core_done_i held 1 from before RUN entry. Required response: no UNLOAD until core_done_i falls and rises again.
